// File: rtl/icache_branch_prefetch_sched_if.sv
// Refill-side and L1-prefetch-side signals of the branch prefetch scheduler.
// The master modport is the scheduler's view; slave is the surrounding logic.
interface icache_branch_prefetch_sched_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 128
);
    logic                  line_valid_i;
    logic                  line_ready_o;
    logic [ADDR_WIDTH-1:0] line_addr_i;
    logic [LINE_WIDTH-1:0] line_data_i;
    logic                  pf_req_o;
    logic [ADDR_WIDTH-1:0] pf_addr_o;
    logic                  pf_gnt_i;

    modport master (
        input  line_valid_i, line_addr_i, line_data_i, pf_gnt_i,
        output line_ready_o, pf_req_o, pf_addr_o
    );

    modport slave (
        output line_valid_i, line_addr_i, line_data_i, pf_gnt_i,
        input  line_ready_o, pf_req_o, pf_addr_o
    );
endinterface

// File: rtl/icache_branch_prefetch_sched.sv
// L0 I-cache prefetch scheduler: scans a refilled line one word per cycle for
// conditional branches and JAL, queues their target lines (plus the next
// sequential line) and issues them to the L1 over a req/gnt handshake.
module icache_branch_prefetch_sched #(
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NEXT_LINE  = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    icache_branch_prefetch_sched_if.master bus,
    output logic busy_o
);
    localparam int unsigned N          = LINE_WIDTH / 32;
    localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;
    localparam int unsigned IDX_W      = $clog2(N + 1);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

    typedef enum logic {IDLE, SCAN} state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LINE_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic                  last_valid_q, last_valid_d;
    logic [PTR_W-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [31:0]           word;
    logic [ADDR_WIDTH-1:0] pc, imm_b, imm_j, target, cand;
    logic                  is_b, is_j, in_tail, full, pop, need, push, line_ready;

    // Decode the word under examination; the data register shifts so word idx sits at bit 0.
    always_comb begin
        word    = data_q[31:0];
        pc      = base_q + ADDR_WIDTH'({idx_q, 2'b00});
        imm_b   = {{(ADDR_WIDTH-12){word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
        imm_j   = {{(ADDR_WIDTH-20){word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
        is_b    = (word[6:0] == 7'b1100011) && (word[14:13] != 2'b01);
        is_j    = (word[6:0] == 7'b1101111);
        target  = pc + (is_j ? imm_j : imm_b);
        in_tail = (idx_q == IDX_W'(N));
        cand    = in_tail ? (base_q + ADDR_WIDTH'(LINE_BYTES)) : (target & ~OFF_MASK);
    end

    // Push/pop arbitration shared by the FSM and the queue.
    always_comb begin
        full       = (cnt_q == CNT_W'(FIFO_DEPTH));
        pop        = (cnt_q != '0) && bus.pf_gnt_i;
        need       = (state_q == SCAN)
                   && (in_tail || ((is_b || is_j) && (cand != base_q)))
                   && !(last_valid_q && (cand == last_q));
        push       = need && (!full || pop) && !flush_i;
        line_ready = (state_q == IDLE) && !flush_i;
    end

    // Next-state logic for the scan FSM, dedup tracker and queue pointers.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        base_d       = base_q;
        data_d       = data_q;
        last_d       = last_q;
        last_valid_d = last_valid_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        cnt_d        = cnt_q;
        if (flush_i) begin
            state_d      = IDLE;
            idx_d        = '0;
            last_valid_d = 1'b0;
            rd_d         = '0;
            wr_d         = '0;
            cnt_d        = '0;
        end else begin
            if (pop) begin
                rd_d = (rd_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
            end
            if (push) begin
                wr_d         = (wr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
                last_d       = cand;
                last_valid_d = 1'b1;
            end
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
            if (line_ready && bus.line_valid_i) begin
                state_d = SCAN;
                idx_d   = '0;
                base_d  = bus.line_addr_i & ~OFF_MASK;
                data_d  = bus.line_data_i;
            end else if ((state_q == SCAN) && (!need || push)) begin
                if (in_tail || ((idx_q == IDX_W'(N - 1)) && (NEXT_LINE == 0))) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                    data_d = data_q >> 32;
                end
            end
        end
    end

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            base_q       <= '0;
            data_q       <= '0;
            last_q       <= '0;
            last_valid_q <= 1'b0;
            rd_q         <= '0;
            wr_q         <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            base_q       <= base_d;
            data_q       <= data_d;
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
        end
    end

    // Queue storage; contents are only visible through the count, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_q] <= cand;
        end
    end

    assign bus.line_ready_o = line_ready;
    assign bus.pf_req_o     = (cnt_q != '0);
    assign bus.pf_addr_o    = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign busy_o           = (state_q != IDLE) || (cnt_q != '0);
endmodule

// File: tb/tb_icache_branch_prefetch_sched.sv
// Bench for icache_branch_prefetch_sched: directed scenarios plus random
// traffic, all outputs checked every cycle against a queue-based model.
module tb_icache_branch_prefetch_sched;
    localparam int unsigned LW    = 128;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NW    = LW / 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;

    icache_branch_prefetch_sched_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    icache_branch_prefetch_sched #(
        .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .NEXT_LINE(1)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bus), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] issued[$];
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- encoders for stimulus ----------------
    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd1, 5'd2, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction
    function automatic logic [31:0] b_to(input logic [2:0] f3, input logic [31:0] tgt, input logic [31:0] pc);
        logic [31:0] d;
        d = tgt - pc;
        return enc_b(f3, d[12:0]);
    endfunction
    function automatic logic [31:0] j_to(input logic [31:0] tgt, input logic [31:0] pc);
        logic [31:0] d;
        d = tgt - pc;
        return enc_j(d[20:0]);
    endfunction

    // ---------------- reference model ----------------
    // Target of a branch/JAL word computed with integer arithmetic on the fields.
    function automatic bit model_target(input logic [31:0] w, input logic [31:0] pc, output logic [31:0] tgt);
        int op, f3, imm;
        op  = int'(w & 32'h7F);
        f3  = int'((w >> 12) & 32'h7);
        tgt = '0;
        if (op == 'h63 && f3 != 2 && f3 != 3) begin
            imm = (((w >> 31) & 1) != 0 ? -4096 : 0) + int'((w >> 7) & 1) * 2048
                + int'((w >> 25) & 32'h3F) * 32 + int'((w >> 8) & 32'hF) * 2;
        end else if (op == 'h6F) begin
            imm = (((w >> 31) & 1) != 0 ? -(1 << 20) : 0) + int'((w >> 12) & 32'hFF) * 4096
                + int'((w >> 20) & 1) * 2048 + int'((w >> 21) & 32'h3FF) * 2;
        end else begin
            return 1'b0;
        end
        tgt = pc + 32'(imm);
        return 1'b1;
    endfunction

    logic [31:0] mq[$];
    bit          m_scan = 1'b0;
    int          m_pos = 0;
    logic [31:0] m_base = '0;
    logic [31:0] m_words[NW];
    logic [31:0] m_last = '0;
    bit          m_lastv = 1'b0;

    // Compare DUT with the model at every negedge, then advance the model.
    initial begin
        bit          pop, need, room, hit;
        logic [31:0] cand, tgt;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("pf_req", 32'(bus.pf_req_o), 32'(mq.size() != 0));
            chk("pf_addr", bus.pf_addr_o, (mq.size() != 0) ? mq[0] : 32'h0);
            chk("line_ready", 32'(bus.line_ready_o), 32'(!m_scan && !flush));
            chk("busy", 32'(busy), 32'(m_scan || mq.size() != 0));
            if (bus.pf_req_o && bus.pf_gnt_i && rst_n) issued.push_back(bus.pf_addr_o);
            if (!rst_n) begin
                mq.delete(); m_scan = 0; m_pos = 0; m_lastv = 0; m_last = '0;
            end else if (flush) begin
                mq.delete(); m_scan = 0; m_lastv = 0;
            end else begin
                pop  = (mq.size() != 0) && bus.pf_gnt_i;
                need = 0;
                cand = '0;
                if (m_scan) begin
                    if (m_pos < NW) begin
                        hit = model_target(m_words[m_pos], m_base + 32'(4 * m_pos), tgt);
                        cand = tgt & ~32'hF;
                        need = hit && (cand != m_base);
                    end else begin
                        cand = m_base + 32'd16;
                        need = 1;
                    end
                    if (need && m_lastv && cand == m_last) need = 0;
                end
                room = (mq.size() < DEPTH) || pop;
                if (pop) void'(mq.pop_front());
                if (need && room) begin
                    mq.push_back(cand); m_last = cand; m_lastv = 1;
                end
                if (m_scan) begin
                    if (!need || room) begin
                        m_pos++;
                        if (m_pos > NW) m_scan = 0;
                    end
                end else if (bus.line_valid_i) begin
                    m_scan = 1; m_pos = 0;
                    m_base = bus.line_addr_i & ~32'hF;
                    for (int k = 0; k < NW; k++) m_words[k] = bus.line_data_i[32*k +: 32];
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] addr, input logic [LW-1:0] data);
        bus.line_addr_i  = addr;
        bus.line_data_i  = data;
        bus.line_valid_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.line_ready_o) begin
                step();
                break;
            end
            step();
        end
        bus.line_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            step();
        end
        chk(name, 32'(busy), 32'h0);
    endtask

    task automatic check_log(input string name);
        chk({name, "_count"}, 32'(issued.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < issued.size(); i++)
            chk({name, "_addr"}, issued[i], exp_q[i]);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 4))
            0: return NOP;
            1: return $urandom;
            2: return enc_b(3'($urandom_range(0, 7)), 13'($urandom_range(0, 63) * 2) - 13'd64);
            3: return enc_j(21'($urandom_range(0, 1023) * 2) - 21'd1024);
            default: return enc_b(3'($urandom_range(0, 7)), 13'($urandom_range(0, 15) * 2) - 13'd8);
        endcase
    endfunction

    initial begin
        bus.line_valid_i = 1'b0;
        bus.line_addr_i  = '0;
        bus.line_data_i  = '0;
        bus.pf_gnt_i     = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus.line_ready_o), 32'h1);
        chk("rst_req", 32'(bus.pf_req_o), 32'h0);
        chk("rst_addr", bus.pf_addr_o, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        step();

        // Branch and JAL targets
        issued.delete();
        bus.pf_gnt_i = 1'b1;
        offer(32'h1000, {NOP, 32'h801FF06F, 32'h04000063, NOP});
        wait_idle("t1_idle");
        exp_q = '{32'h1040, 32'h0800, 32'h1010};
        check_log("t1");

        // Same-line drop and dedup
        issued.delete();
        offer(32'h2000, {NOP, b_to(3'd4, 32'h3004, 32'h2008), b_to(3'd1, 32'h3000, 32'h2004),
                         b_to(3'd0, 32'h2004, 32'h2000)});
        wait_idle("t2_idle");
        exp_q = '{32'h3000, 32'h2010};
        check_log("t2");

        // Backpressure: full queue stalls the next-line push
        issued.delete();
        bus.pf_gnt_i = 1'b0;
        offer(32'h1000, {j_to(32'h7000, 32'h100C), j_to(32'h6000, 32'h1008),
                         j_to(32'h5000, 32'h1004), j_to(32'h4000, 32'h1000)});
        repeat (12) step();
        @(negedge clk);
        chk("t3_busy", 32'(busy), 32'h1);
        chk("t3_ready_stall", 32'(bus.line_ready_o), 32'h0);
        chk("t3_head", bus.pf_addr_o, 32'h4000);
        step();
        bus.pf_gnt_i = 1'b1;
        step();
        bus.pf_gnt_i = 1'b0;
        @(negedge clk);
        chk("t3_ready_after_pop", 32'(bus.line_ready_o), 32'h1);
        chk("t3_head_after_pop", bus.pf_addr_o, 32'h5000);
        step();
        bus.pf_gnt_i = 1'b1;
        wait_idle("t3_idle");
        exp_q = '{32'h4000, 32'h5000, 32'h6000, 32'h7000, 32'h1010};
        check_log("t3");

        // Flush mid-scan with a grant in the same cycle
        issued.delete();
        bus.pf_gnt_i = 1'b0;
        offer(32'h9000, {j_to(32'hD000, 32'h900C), j_to(32'hC000, 32'h9008),
                         j_to(32'hB000, 32'h9004), j_to(32'hA000, 32'h9000)});
        step();
        step();
        flush = 1'b1;
        bus.pf_gnt_i = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("t4_req", 32'(bus.pf_req_o), 32'h0);
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_ready", 32'(bus.line_ready_o), 32'h1);
        repeat (10) step();
        exp_q = '{32'hA000};
        check_log("t4");

        // Reset mid-request clears the dedup history
        issued.delete();
        bus.pf_gnt_i = 1'b0;
        offer(32'hE000, {j_to(32'hF000, 32'hE00C), NOP, NOP, NOP});
        repeat (8) step();
        chk("t5_req_before_rst", 32'(bus.pf_req_o), 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ready", 32'(bus.line_ready_o), 32'h1);
        chk("t5_req", 32'(bus.pf_req_o), 32'h0);
        chk("t5_addr", bus.pf_addr_o, 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        step();
        bus.pf_gnt_i = 1'b1;
        offer(32'hE000, {NOP, NOP, NOP, b_to(3'd5, 32'hE010, 32'hE000)});
        wait_idle("t5_idle");
        exp_q = '{32'hE010};
        check_log("t5");

        // Next-line wrap-around
        issued.delete();
        offer(32'hFFFF_FFF0, {NOP, NOP, NOP, NOP});
        wait_idle("t6_idle");
        exp_q = '{32'h0000_0000};
        check_log("t6");

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            flush            = ($urandom_range(0, 63) == 0);
            bus.pf_gnt_i     = ($urandom_range(0, 3) != 0);
            bus.line_valid_i = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0: bus.line_addr_i = 32'h1000 + 32'($urandom_range(0, 15));
                1: bus.line_addr_i = 32'h1010 + 32'($urandom_range(0, 15));
                2: bus.line_addr_i = 32'h2000 + 32'($urandom_range(0, 15));
                default: bus.line_addr_i = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            endcase
            bus.line_data_i = {rand_word(), rand_word(), rand_word(), rand_word()};
            step();
        end
        flush = 1'b0;
        bus.line_valid_i = 1'b0;
        bus.pf_gnt_i = 1'b1;
        wait_idle("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
